// File: rtl/uart_cfg_rx_if.sv
// Configuration-receiver signal bundle: serial command line in, runtime
// configuration registers and status pulses out.
interface uart_cfg_rx_if;
    logic        rx;
    logic [31:0] m_convert_config_data;
    logic [15:0] m_large_thres;
    logic [15:0] m_small_thres;
    logic [7:0]  m_small_nums;
    logic        m_cfg_update;
    logic [1:0]  m_cfg_addr;
    logic        m_frame_err;
    logic        m_chk_err;

    modport master (
        input  rx,
        output m_convert_config_data,
        output m_large_thres,
        output m_small_thres,
        output m_small_nums,
        output m_cfg_update,
        output m_cfg_addr,
        output m_frame_err,
        output m_chk_err
    );

    modport slave (
        output rx,
        input  m_convert_config_data,
        input  m_large_thres,
        input  m_small_thres,
        input  m_small_nums,
        input  m_cfg_update,
        input  m_cfg_addr,
        input  m_frame_err,
        input  m_chk_err
    );
endinterface

// File: rtl/uart_cfg_rx.sv
// 8N1 UART receiver that parses 7-byte checksummed configuration packets
// (A5, ADDR, D3..D0, CHK) and drives the runtime configuration registers.
module uart_cfg_rx #(
    parameter int unsigned CLK_FREQ        = 50000000,
    parameter int unsigned BAUD            = 115200,
    parameter int unsigned TIMEOUT_BITS    = 20,
    parameter logic [31:0] DEF_FREQ_WORD   = 32'h051EB852,
    parameter logic [15:0] DEF_LARGE_THRES = 16'd150,
    parameter logic [15:0] DEF_SMALL_THRES = 16'd30,
    parameter logic [7:0]  DEF_SMALL_NUMS  = 8'd20
) (
    input logic           sys_clk,
    input logic           sys_rst,
    uart_cfg_rx_if.master bus
);

    localparam int unsigned CPB  = CLK_FREQ / BAUD;
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned TMO  = TIMEOUT_BITS * CPB;
    localparam int unsigned CW   = $clog2(CPB + 1);
    localparam int unsigned TW   = $clog2(TMO + 1);

    localparam logic [CW-1:0] CPB_M1_C = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_C   = CW'(HALF);
    localparam logic [TW-1:0] TMO_C    = TW'(TMO);
    localparam logic [7:0]    HDR      = 8'hA5;

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_e;
    typedef enum logic [2:0] {P_HUNT, P_ADDR, P_D3, P_D2, P_D1, P_D0, P_CHK} pstate_e;

    // ---------------- rx synchroniser ----------------
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // ---------------- byte FSM ----------------
    bstate_e      bstate_q, bstate_d;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          byte_valid_q, frame_err_q;

    logic start_edge, bit_tick, half_tick;
    logic cnt_clr, bit_idx_clr, sample_data, stop_ok, stop_bad;

    // The edge needs a high-to-low transition, so a line stuck low after a
    // frame error cannot re-arm the receiver.
    assign start_edge = rx_prev_q & ~rx_sync_q;
    assign bit_tick   = (cnt_q == CPB_M1_C);
    assign half_tick  = (cnt_q == HALF_C);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) bstate_q <= B_IDLE;
        else         bstate_q <= bstate_d;
    end

    always_comb begin
        bstate_d = bstate_q;
        unique case (bstate_q)
            B_IDLE:  if (start_edge) bstate_d = B_START;
            B_START: if (half_tick)  bstate_d = rx_sync_q ? B_IDLE : B_DATA;
            B_DATA:  if (bit_tick && bit_idx_q == 3'd7) bstate_d = B_STOP;
            B_STOP:  if (bit_tick)   bstate_d = B_IDLE;
            default: bstate_d = B_IDLE;
        endcase
    end

    always_comb begin
        cnt_clr     = 1'b0;
        bit_idx_clr = 1'b0;
        sample_data = 1'b0;
        stop_ok     = 1'b0;
        stop_bad    = 1'b0;
        unique case (bstate_q)
            B_IDLE:  cnt_clr = 1'b1;
            B_START: begin
                cnt_clr     = half_tick;
                bit_idx_clr = half_tick;
            end
            B_DATA:  begin
                cnt_clr     = bit_tick;
                sample_data = bit_tick;
            end
            B_STOP:  begin
                stop_ok  = bit_tick &  rx_sync_q;
                stop_bad = bit_tick & ~rx_sync_q;
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_clr ? '0 : cnt_q + 1'b1;
            if (bit_idx_clr)      bit_idx_q <= '0;
            else if (sample_data) bit_idx_q <= bit_idx_q + 1'b1;
            if (sample_data) shift_q <= {rx_sync_q, shift_q[7:1]};
            byte_valid_q <= stop_ok;
            frame_err_q  <= stop_bad;
        end
    end

    // ---------------- packet parser FSM ----------------
    pstate_e       pstate_q, pstate_d;
    logic [TW-1:0] tmo_q;
    logic [7:0]    addr_q, sum_q;
    logic [31:0]   data_q;
    logic          tmo_hit, commit_ok, commit_bad, cap_addr, cap_data;

    assign tmo_hit = (tmo_q == TMO_C);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) pstate_q <= P_HUNT;
        else         pstate_q <= pstate_d;
    end

    always_comb begin
        pstate_d = pstate_q;
        if (frame_err_q) begin
            pstate_d = P_HUNT;
        end else if (byte_valid_q) begin
            unique case (pstate_q)
                P_HUNT:  if (shift_q == HDR) pstate_d = P_ADDR;
                P_ADDR:  pstate_d = P_D3;
                P_D3:    pstate_d = P_D2;
                P_D2:    pstate_d = P_D1;
                P_D1:    pstate_d = P_D0;
                P_D0:    pstate_d = P_CHK;
                P_CHK:   pstate_d = P_HUNT;
                default: pstate_d = P_HUNT;
            endcase
        end else if (tmo_hit) begin
            pstate_d = P_HUNT;
        end
    end

    always_comb begin
        cap_addr   = 1'b0;
        cap_data   = 1'b0;
        commit_ok  = 1'b0;
        commit_bad = 1'b0;
        if (byte_valid_q) begin
            unique case (pstate_q)
                P_ADDR:                  cap_addr = 1'b1;
                P_D3, P_D2, P_D1, P_D0:  cap_data = 1'b1;
                P_CHK: begin
                    commit_ok  = (shift_q == sum_q);
                    commit_bad = (shift_q != sum_q);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tmo_q  <= '0;
            addr_q <= '0;
            sum_q  <= '0;
            data_q <= '0;
        end else begin
            if (pstate_q == P_HUNT || byte_valid_q) tmo_q <= '0;
            else                                    tmo_q <= tmo_q + 1'b1;
            if (cap_addr) begin
                addr_q <= shift_q;
                sum_q  <= shift_q;
            end
            if (cap_data) begin
                data_q <= {data_q[23:0], shift_q};
                sum_q  <= sum_q + shift_q;
            end
        end
    end

    // ---------------- configuration registers ----------------
    logic [31:0] freq_q;
    logic [15:0] large_q, small_q;
    logic [7:0]  nums_q;
    logic [1:0]  cfg_addr_q;
    logic        upd_q, chk_err_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            freq_q     <= DEF_FREQ_WORD;
            large_q    <= DEF_LARGE_THRES;
            small_q    <= DEF_SMALL_THRES;
            nums_q     <= DEF_SMALL_NUMS;
            cfg_addr_q <= '0;
            upd_q      <= 1'b0;
            chk_err_q  <= 1'b0;
        end else begin
            upd_q     <= 1'b0;
            chk_err_q <= commit_bad;
            if (commit_ok && addr_q < 8'd4) begin
                upd_q      <= 1'b1;
                cfg_addr_q <= addr_q[1:0];
                unique case (addr_q[1:0])
                    2'd0: freq_q  <= data_q;
                    2'd1: large_q <= data_q[15:0];
                    2'd2: small_q <= data_q[15:0];
                    2'd3: nums_q  <= data_q[7:0];
                    default: ;
                endcase
            end
        end
    end

    assign bus.m_convert_config_data = freq_q;
    assign bus.m_large_thres         = large_q;
    assign bus.m_small_thres         = small_q;
    assign bus.m_small_nums          = nums_q;
    assign bus.m_cfg_update          = upd_q;
    assign bus.m_cfg_addr            = cfg_addr_q;
    assign bus.m_frame_err           = frame_err_q;
    assign bus.m_chk_err             = chk_err_q;

endmodule
